pb_data_debounce_capture: RTL and testbench

//  Downstream stage of the 4-bit PB_DATA output PIO: consumes its out_port
//  (software-emulated pushbuttons) as pb_in, then synchronises and debounces each bit.

---
 rtl/pb_data_debounce_capture.sv | 124 ++++++++++++
 tb/tb_pb_data_debounce_capture.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_data_debounce_capture.sv
// PB_DATA debounce and edge capture stage.
// Sync, per-bit debounce, rise/fall pulses, Avalon-MM regs, level IRQ.
module pb_data_debounce_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pb_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] pb_level,
  output logic [WIDTH-1:0] pb_rise,
  output logic [WIDTH-1:0] pb_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_RSVD = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic             wr;
  logic [WIDTH-1:0] w1c;
  logic             unused_wdata;

  assign wr  = chipselect & ~write_n;
  assign w1c = (wr && address == A_EDGE) ?
               writedata[WIDTH-1:0] : '0;

  assign unused_wdata = ^writedata[31:WIDTH];

  assign s1_d = pb_in;
  assign s2_d = s1_q;

  // Per-bit debounce: a level change commits only after
  // DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    lvl_d  = lvl_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i]  = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Register-file next state; a rise on the same edge as a
  // W1C clear keeps the capture bit set.
  always_comb begin
    mask_d = mask_q;
    if (wr && address == A_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~w1c) | rise_d;
  end

  // State update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  // Zero-latency read mux, zero-extended.
  always_comb begin
    readdata = '0;
    unique case (address)
      A_DATA: readdata[WIDTH-1:0] = lvl_q;
      A_RSVD: readdata = '0;
      A_MASK: readdata[WIDTH-1:0] = mask_q;
      A_EDGE: readdata[WIDTH-1:0] = edge_q;
      default: readdata = '0;
    endcase
  end

  assign irq      = |(edge_q & mask_q);
  assign pb_level = lvl_q;
  assign pb_rise  = rise_q;
  assign pb_fall  = fall_q;

endmodule

// File: tb/tb_pb_data_debounce_capture.sv
// Bench for pb_data_debounce_capture.
// Window-based reference model, directed and random scenarios.
module tb_pb_data_debounce_capture;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  pb_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  pb_level;
  logic [3:0]  pb_rise;
  logic [3:0]  pb_fall;

  int total;
  int bad;

  // model: input history (index 0 newest), and register values
  logic [3:0] m_hist [0:D];
  logic [3:0] m_lvl;
  logic [3:0] m_rise;
  logic [3:0] m_fall;
  logic [3:0] m_mask;
  logic [3:0] m_edge;
  logic       m_irq;

  pb_data_debounce_capture #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pb_in(pb_in),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .pb_level(pb_level),
    .pb_rise(pb_rise),
    .pb_fall(pb_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[3:0] = m_lvl;
      2'd2: r[3:0] = m_mask;
      2'd3: r[3:0] = m_edge;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advance model on current inputs, then one clock edge.
  task automatic tick();
    logic [3:0] nl;
    logic [3:0] clr;
    logic       diff;
    if (reset) begin
      for (int k = 0; k <= D; k++) m_hist[k] = '0;
      m_lvl = '0; m_rise = '0; m_fall = '0;
      m_mask = '0; m_edge = '0;
    end else begin
      nl = m_lvl;
      for (int b = 0; b < 4; b++) begin
        diff = 1'b1;
        for (int k = 1; k <= D; k++)
          if (m_hist[k][b] == m_lvl[b]) diff = 1'b0;
        if (diff) nl[b] = ~m_lvl[b];
      end
      clr = '0;
      if (chipselect && !write_n && address == 2'd3)
        clr = writedata[3:0];
      if (chipselect && !write_n && address == 2'd2)
        m_mask = writedata[3:0];
      m_rise = nl & ~m_lvl;
      m_fall = ~nl & m_lvl;
      m_edge = (m_edge & ~clr) | m_rise;
      m_lvl  = nl;
      for (int k = D; k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = pb_in;
    end
    m_irq = |(m_edge & m_mask);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    pb_in = 4'hF;
    bus_idle();
    tick();
    tick();
    total++;
    if ({pb_level, pb_rise, pb_fall, irq} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outs got=%h exp=0",
               {pb_level, pb_rise, pb_fall, irq});
    end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      rd = readdata;
      total++;
      if (rd !== 32'h0) begin
        bad++;
        $display("FAIL reset_rd%0d got=%h exp=0", a, rd);
      end
    end
    pb_in = 4'h0;
    reset = 1'b0;
    tick();
    total++;
    if ({pb_level, pb_rise, pb_fall, irq} !== 13'h0) begin
      bad++;
      $display("FAIL post_reset got=%h exp=0",
               {pb_level, pb_rise, pb_fall, irq});
    end
  endtask

  task automatic test_step();
    logic [31:0] rd;
    int nrise;
    nrise = 0;
    pb_in = 4'h5;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (pb_rise == 4'h5) nrise++;
      total++;
      if ({pb_level, pb_rise, pb_fall, irq} !==
          {m_lvl, m_rise, m_fall, m_irq}) begin
        bad++;
        $display("FAIL step_model c=%0d got=%h exp=%h", c,
                 {pb_level, pb_rise, pb_fall, irq},
                 {m_lvl, m_rise, m_fall, m_irq});
      end
      if (c == 5) begin
        total++;
        if (pb_level !== 4'h0) begin
          bad++;
          $display("FAIL step_early got=%h exp=0", pb_level);
        end
      end
      if (c == 6) begin
        total++;
        if ({pb_level, pb_rise} !== 8'h55) begin
          bad++;
          $display("FAIL step_edge6 got=%h exp=55",
                   {pb_level, pb_rise});
        end
      end
    end
    total++;
    if (nrise != 1) begin
      bad++;
      $display("FAIL step_rise_count got=%0d exp=1", nrise);
    end
    address = 2'd3;
    #1;
    rd = readdata;
    total++;
    if (rd !== 32'h5) begin
      bad++;
      $display("FAIL step_edgecap got=%h exp=5", rd);
    end
    bus_wr(2'd3, 32'hF);
    pb_in = 4'h0;
    tick();
    bus_idle();
    for (int c = 0; c < 9; c++) tick();
    total++;
    if ({pb_level, m_edge} !== 8'h00 || readdata !== 32'h0) begin
      bad++;
      $display("FAIL step_release got=%h/%h exp=0/0",
               pb_level, readdata);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    logic [3:0]  seen;
    seen = '0;
    pb_in = 4'h1;
    for (int c = 0; c < 3; c++) begin
      tick();
      seen |= pb_rise | pb_fall | pb_level;
    end
    pb_in = 4'h0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen |= pb_rise | pb_fall | pb_level;
    end
    total++;
    if (seen !== 4'h0) begin
      bad++;
      $display("FAIL glitch_activity got=%h exp=0", seen);
    end
    address = 2'd3;
    #1;
    rd = readdata;
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL glitch_edgecap got=%h exp=0", rd);
    end
  endtask

  task automatic test_irq();
    int nfall;
    logic irq_seen;
    nfall = 0;
    irq_seen = 1'b0;
    bus_wr(2'd2, 32'h1);
    tick();
    bus_idle();
    pb_in = 4'h1;
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (irq !== 1'b1 || m_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_assert got=%b exp=1", irq);
    end
    bus_wr(2'd3, 32'h1);
    tick();
    bus_idle();
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear got=%b exp=0", irq);
    end
    pb_in = 4'h0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (pb_fall[0]) nfall++;
      irq_seen |= irq;
    end
    total++;
    if (nfall != 1 || irq_seen !== 1'b0) begin
      bad++;
      $display("FAIL irq_release got=fall%0d/irq%b exp=fall1/irq0",
               nfall, irq_seen);
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    pb_in = 4'h4;
    for (int c = 1; c <= 5; c++) tick();
    bus_wr(2'd3, 32'h4);
    tick();
    bus_idle();
    total++;
    if (pb_rise !== 4'h4) begin
      bad++;
      $display("FAIL coll_rise got=%h exp=4", pb_rise);
    end
    address = 2'd3;
    #1;
    rd = readdata;
    total++;
    if (rd !== 32'h4) begin
      bad++;
      $display("FAIL coll_edgecap got=%h exp=4", rd);
    end
    bus_wr(2'd3, 32'hF);
    pb_in = 4'h0;
    tick();
    bus_idle();
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_mid_reset();
    pb_in = 4'h8;
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (pb_level !== 4'h0) begin
      bad++;
      $display("FAIL midrst_level got=%h exp=0", pb_level);
    end
    for (int c = 1; c <= 7; c++) begin
      tick();
      total++;
      if (pb_level[3] !== (c >= 6) ||
          pb_level !== m_lvl) begin
        bad++;
        $display("FAIL midrst_c%0d got=%h exp=%h", c,
                 pb_level, m_lvl);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int r;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0)
        pb_in = pb_in ^ 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      if (r == 0) bus_wr(2'd2, $urandom);
      else if (r == 1) bus_wr(2'd3, $urandom);
      else begin
        bus_idle();
        address = 2'($urandom_range(0, 3));
      end
      tick();
      rd = readdata;
      total++;
      if ({pb_level, pb_rise, pb_fall, irq} !==
          {m_lvl, m_rise, m_fall, m_irq} ||
          rd !== m_read(address)) begin
        bad++;
        $display("FAIL rand c=%0d got=%h/%h exp=%h/%h", c,
                 {pb_level, pb_rise, pb_fall, irq}, rd,
                 {m_lvl, m_rise, m_fall, m_irq},
                 m_read(address));
      end
    end
    bus_idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    pb_in = '0;
    address = '0;
    bus_idle();
    for (int k = 0; k <= D; k++) m_hist[k] = '0;
    m_lvl = '0; m_rise = '0; m_fall = '0;
    m_mask = '0; m_edge = '0; m_irq = 1'b0;
    test_reset();
    test_step();
    test_glitch();
    test_irq();
    test_collision();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
